// File: rtl/lcd_hd44780_driver.sv
// Purpose : drive a 16x2 HD44780 LCD from a 32-nibble digit buffer (power-up, init, then line refreshes).
// Latency : refresh begins the cycle after lcd_data_in differs from the displayed shadow; 34 writes per frame.
// Backpressure: none; input changes during a frame are picked up by an immediate follow-on refresh.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn   clock, synchronous active-low reset
//   lcd_data_in[127:0]          digit buffer, nibble i = lcd_data_in[4*i +: 4]
//   LCD_DATA/RS/RW/EN/ON        LCD pins (write-only bus, RW tied low)
//   busy                        high during power-up, init and refresh
//   frame_done                  one-cycle pulse at the end of each refresh
module lcd_hd44780_driver #(
  parameter int unsigned PWRUP_WAIT_CYC = 750000,
  parameter int unsigned EN_PULSE_CYC   = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLR_WAIT_CYC   = 82000
) (
  input  logic         s_axi_aclk,
  input  logic         s_axi_aresetn,
  input  logic [127:0] lcd_data_in,
  output logic [7:0]   LCD_DATA,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_EN,
  output logic         LCD_ON,
  output logic         busy,
  output logic         frame_done
);

  localparam logic [19:0] PWRUP_LAST = 20'(PWRUP_WAIT_CYC - 1);
  localparam logic [19:0] PULSE_LAST = 20'(EN_PULSE_CYC - 1);
  localparam logic [19:0] CMD_LAST   = 20'(CMD_WAIT_CYC - 1);
  localparam logic [19:0] CLR_LAST   = 20'(CLR_WAIT_CYC - 1);

  typedef enum logic [1:0] {ST_PWRUP, ST_INIT, ST_REFRESH, ST_IDLE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  state_t         state;
  phase_t         phase;
  logic [19:0]    cnt;
  logic [5:0]     idx;
  logic [127:0]   shadow;
  logic [8:0]     next_wr;   // {rs, data} of the write that follows the current one
  logic [19:0]    wait_last;

  assign LCD_RW = 1'b0;

  function automatic logic [7:0] nib_char(input logic [3:0] d);
    if (d < 4'd10) return 8'h30 + {4'h0, d};
    else           return 8'h41 + {4'h0, d - 4'd10};
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Write k of a frame: line-1 address, 16 chars, line-2 address, 16 chars.
  function automatic logic [8:0] refresh_write(input logic [5:0] k, input logic [127:0] digits);
    logic [4:0] n;
    if (k == 6'd0)  return {1'b0, 8'h80};
    if (k == 6'd17) return {1'b0, 8'hC0};
    n = (k < 6'd17) ? 5'(k - 6'd1) : 5'(k - 6'd2);
    return {1'b1, nib_char(digits[{n, 2'b00} +: 4])};
  endfunction

  always_comb begin
    next_wr = {1'b0, 8'h80};
    case (state)
      ST_PWRUP:   next_wr = {1'b0, init_cmd(2'd0)};
      ST_INIT:    next_wr = (idx == 6'd3) ? {1'b0, 8'h80} : {1'b0, init_cmd(2'(idx + 6'd1))};
      ST_REFRESH: next_wr = refresh_write(idx + 6'd1, shadow);
      default:    next_wr = {1'b0, 8'h80};
    endcase
  end

  // Clear-display needs the long settle time; character data never equals 0x01 with RS low.
  assign wait_last = (LCD_DATA == 8'h01 && !LCD_RS) ? CLR_LAST : CMD_LAST;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state      <= ST_PWRUP;
      phase      <= PH_SETUP;
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      LCD_DATA   <= 8'h00;
      LCD_RS     <= 1'b0;
      LCD_EN     <= 1'b0;
      LCD_ON     <= 1'b0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      LCD_ON     <= 1'b1;
      frame_done <= 1'b0;
      case (state)
        ST_PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            cnt                <= '0;
            idx                <= '0;
            phase              <= PH_SETUP;
            state              <= ST_INIT;
            {LCD_RS, LCD_DATA} <= next_wr;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end

        ST_IDLE: begin
          if (lcd_data_in != shadow) begin
            shadow             <= lcd_data_in;
            busy               <= 1'b1;
            state              <= ST_REFRESH;
            idx                <= '0;
            cnt                <= '0;
            phase              <= PH_SETUP;
            {LCD_RS, LCD_DATA} <= next_wr;
          end
        end

        // INIT and REFRESH share the SETUP/PULSE/WAIT write engine; the bus was loaded on entry to SETUP.
        default: begin
          case (phase)
            PH_SETUP: begin
              LCD_EN <= 1'b1;
              cnt    <= '0;
              phase  <= PH_PULSE;
            end
            PH_PULSE: begin
              if (cnt == PULSE_LAST) begin
                LCD_EN <= 1'b0;
                cnt    <= '0;
                phase  <= PH_WAIT;
              end else begin
                cnt <= cnt + 20'd1;
              end
            end
            default: begin
              if (cnt == wait_last) begin
                cnt   <= '0;
                phase <= PH_SETUP;
                if (state == ST_INIT && idx == 6'd3) begin
                  // Init always falls through into a first refresh, whatever the input.
                  state              <= ST_REFRESH;
                  idx                <= '0;
                  shadow             <= lcd_data_in;
                  {LCD_RS, LCD_DATA} <= next_wr;
                end else if (state == ST_REFRESH && idx == 6'd33) begin
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                end else begin
                  idx                <= idx + 6'd1;
                  {LCD_RS, LCD_DATA} <= next_wr;
                end
              end else begin
                cnt <= cnt + 20'd1;
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule
